// File: rtl/aap_dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (port 0) and debug (port 1) share a
// byte-wide memory. Word accesses take two byte transfers, little-endian.
module aap_dmem_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_word,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_word,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic [15:0] m_raddr,
    output logic [15:0] m_waddr,
    input  logic [7:0]  m_rdata,
    output logic [7:0]  m_wdata,
    output logic        m_we
);

    typedef enum logic [2:0] {IDLE, LO, HI, CAP, ACK} state_t;

    state_t      state, state_nx;
    logic        last_gnt;
    logic        gnt_id;
    logic        gnt_valid;
    logic        gnt_sel;
    logic        sel_we;
    logic        sel_word;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        l_we;
    logic        l_word;
    logic [15:0] l_addr;
    logic [15:0] l_wdata;
    logic [7:0]  lo_byte;
    logic [15:0] rd_result;
    logic [15:0] m_addr;
    logic [7:0]  wdata_q;
    logic        we_q;

    // Arbitration among current requests and mux of the winner's fields
    always_comb begin
        gnt_valid = p0_req | p1_req;
        if (p0_req && p1_req) begin
            gnt_sel = (FAIR != 0) ? ~last_gnt : 1'b0;
        end else begin
            gnt_sel = p1_req;
        end
        sel_we    = gnt_sel ? p1_we    : p0_we;
        sel_word  = gnt_sel ? p1_word  : p0_word;
        sel_addr  = gnt_sel ? p1_addr  : p0_addr;
        sel_wdata = gnt_sel ? p1_wdata : p0_wdata;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_valid ? LO : IDLE;
            LO:      state_nx = l_word ? HI : (l_we ? ACK : CAP);
            HI:      state_nx = l_we ? ACK : CAP;
            CAP:     state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Final read value, formed in CAP from the byte arriving this cycle
    assign rd_result = l_word ? {m_rdata, lo_byte} : {8'h00, m_rdata};

    // Datapath: grant latching, memory drive registers, capture and ack
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            l_we     <= 1'b0;
            l_word   <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            lo_byte  <= '0;
            m_addr   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            we_q   <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        last_gnt <= gnt_sel;
                        gnt_id   <= gnt_sel;
                        l_we     <= sel_we;
                        l_word   <= sel_word;
                        l_addr   <= sel_addr;
                        l_wdata  <= sel_wdata;
                        m_addr   <= sel_addr;
                        we_q     <= sel_we;
                        if (sel_we) wdata_q <= sel_wdata[7:0];
                    end
                end
                LO: begin
                    if (l_word) begin
                        m_addr <= l_addr + 16'd1;
                        we_q   <= l_we;
                        if (l_we) wdata_q <= l_wdata[15:8];
                    end
                end
                HI: begin
                    if (!l_we) lo_byte <= m_rdata;
                end
                default: ;
            endcase
            if (state != ACK && state_nx == ACK) begin
                if (gnt_id) p1_ack <= 1'b1;
                else        p0_ack <= 1'b1;
                if (!l_we) begin
                    if (gnt_id) p1_rdata <= rd_result;
                    else        p0_rdata <= rd_result;
                end
            end
        end
    end

    // Write strobe is registered with the address; reset gates it in the same
    // cycle so an aborted transfer cannot land its pending byte.
    assign m_we    = we_q & ~rst;
    assign m_wdata = wdata_q;
    assign m_raddr = m_addr;
    assign m_waddr = m_addr;

endmodule

// File: tb/tb_aap_dmem_arbiter.sv
// Scoreboard bench for aap_dmem_arbiter: a byte memory model, one round-robin
// instance (checked fully) and one fixed-priority instance (grant order).
module tb_aap_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p0_word = 0;
    logic [15:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 0, p1_we = 0, p1_word = 0;
    logic [15:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack, m_we;
    logic [15:0] p0_rdata, p1_rdata, m_raddr, m_waddr;
    logic [7:0]  m_rdata, m_wdata;

    logic        f_p0_ack, f_p1_ack, f_m_we;
    logic [15:0] f_p0_rdata, f_p1_rdata, f_m_raddr, f_m_waddr;
    logic [7:0]  f_m_wdata;
    logic [7:0]  f_m_rdata = 8'h00;

    logic [7:0]  mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [7:0]  tb_data = '0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          port;
        int          lat;
        bit          rd;
        logic [15:0] rdata;
    } exp_t;
    exp_t sbq[$];

    aap_dmem_arbiter #(.FAIR(1)) u_dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_word(p0_word), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_rdata(m_rdata),
        .m_wdata(m_wdata), .m_we(m_we)
    );

    aap_dmem_arbiter #(.FAIR(0)) u_fix (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_word(p0_word), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
        .m_raddr(f_m_raddr), .m_waddr(f_m_waddr), .m_rdata(f_m_rdata),
        .m_wdata(f_m_wdata), .m_we(f_m_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: synchronous write, read data registered one cycle later
    always @(posedge clk) begin
        if (tb_we)     mem[tb_addr] <= tb_data;
        else if (m_we) mem[m_waddr] <= m_wdata;
        m_rdata <= mem[m_raddr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic drive_p(input bit port, input bit we, input bit word,
                           input logic [15:0] a, input logic [15:0] wd);
        if (port) begin
            p1_req = 1; p1_we = we; p1_word = word; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_req = 1; p0_we = we; p0_word = word; p0_addr = a; p0_wdata = wd;
        end
    endtask

    task automatic release_p(input bit port);
        if (port) p1_req = 0;
        else      p0_req = 0;
    endtask

    task automatic push_exp(input bit port, input int lat, input bit rd,
                            input logic [15:0] rdata);
        exp_t e;
        e.port = port; e.lat = lat; e.rd = rd; e.rdata = rdata;
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                got = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b want 00", {p1_ack, p0_ack}); end
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        checks++; if (m_raddr !== 16'h0000 || m_waddr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h/%h want 0000", m_raddr, m_waddr); end
        checks++; if (m_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h want 00", m_wdata); end
        checks++; if (p0_rdata !== 16'h0000 || p1_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h/%h want 0000", p0_rdata, p1_rdata); end
        checks++; if ({f_p1_ack, f_p0_ack, f_m_we} !== 3'b000) begin failures++; $display("FAIL reset_fix_ctl: got %b want 000", {f_p1_ack, f_p0_ack, f_m_we}); end
        checks++; if ({f_m_raddr, f_m_waddr, f_m_wdata} !== 40'h0) begin failures++; $display("FAIL reset_fix_mem: got %h want 0", {f_m_raddr, f_m_waddr, f_m_wdata}); end
        checks++; if ({f_p0_rdata, f_p1_rdata} !== 32'h0) begin failures++; $display("FAIL reset_fix_rdata: got %h want 0", {f_p0_rdata, f_p1_rdata}); end
        rst = 0;
    endtask

    task automatic test_word_write();
        bit got; exp_t e; int t0;
        poke(16'h1000, 8'h00); poke(16'h1001, 8'h00);
        drive_p(0, 1, 1, 16'h1000, 16'hBEEF);
        t0 = cyc;
        push_exp(0, 3, 0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        checks++; if (m_waddr !== 16'h1000 || m_we !== 1'b1 || m_wdata !== 8'hEF) begin failures++; $display("FAIL ww_lo: got %h %b %h want 1000 1 ef", m_waddr, m_we, m_wdata); end
        @(negedge clk);
        checks++; if (m_waddr !== 16'h1001 || m_we !== 1'b1 || m_wdata !== 8'hBE) begin failures++; $display("FAIL ww_hi: got %h %b %h want 1001 1 be", m_waddr, m_we, m_wdata); end
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin failures++; $display("FAIL ww_early_ack: got %b want 00", {p1_ack, p0_ack}); end
        wait_ack(8, got);
        checks++;
        if (!got) begin failures++; $display("FAIL ww_ack: got timeout want ack"); end
        else begin
            e = sbq.pop_front();
            checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL ww_port: got %b want port %0d", {p1_ack, p0_ack}, e.port); end
            checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL ww_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL ww_we_in_ack: got %b want 0", m_we); end
        end
        @(posedge clk); #1;
        release_p(0);
        checks++; if (mem[16'h1000] !== 8'hEF || mem[16'h1001] !== 8'hBE) begin failures++; $display("FAIL ww_mem: got %h%h want beef", mem[16'h1001], mem[16'h1000]); end
    endtask

    task automatic test_word_read_wrap();
        bit got; exp_t e; int t0; logic [15:0] keep0;
        poke(16'hFFFF, 8'h34); poke(16'h0000, 8'h12);
        keep0 = p0_rdata;
        drive_p(1, 0, 1, 16'hFFFF, 16'h0000);
        t0 = cyc;
        push_exp(1, 4, 1, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        checks++; if (m_raddr !== 16'hFFFF || m_we !== 1'b0) begin failures++; $display("FAIL wr_lo_addr: got %h %b want ffff 0", m_raddr, m_we); end
        @(negedge clk);
        checks++; if (m_raddr !== 16'h0000) begin failures++; $display("FAIL wr_wrap_addr: got %h want 0000", m_raddr); end
        wait_ack(8, got);
        checks++;
        if (!got) begin failures++; $display("FAIL wr_ack: got timeout want ack"); end
        else begin
            e = sbq.pop_front();
            checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL wr_port: got %b want port %0d", {p1_ack, p0_ack}, e.port); end
            checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL wr_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (p1_rdata !== e.rdata) begin failures++; $display("FAIL wr_rdata: got %h want %h", p1_rdata, e.rdata); end
            checks++; if (p0_rdata !== keep0) begin failures++; $display("FAIL wr_other_rdata: got %h want %h", p0_rdata, keep0); end
        end
        @(posedge clk); #1;
        release_p(1);
    endtask

    task automatic test_byte_read();
        bit got; exp_t e; int t0; logic [15:0] keep1;
        poke(16'h0200, 8'h80);
        keep1 = p1_rdata;
        drive_p(0, 0, 0, 16'h0200, 16'hFFFF);
        t0 = cyc;
        push_exp(0, 3, 1, 16'h0080);
        wait_ack(8, got);
        checks++;
        if (!got) begin failures++; $display("FAIL br_ack: got timeout want ack"); end
        else begin
            e = sbq.pop_front();
            checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL br_port: got %b want port %0d", {p1_ack, p0_ack}, e.port); end
            checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL br_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (p0_rdata !== e.rdata) begin failures++; $display("FAIL br_rdata: got %h want %h", p0_rdata, e.rdata); end
            checks++; if (p1_rdata !== keep1) begin failures++; $display("FAIL br_other_rdata: got %h want %h", p1_rdata, keep1); end
        end
        @(posedge clk); #1;
        release_p(0);
    endtask

    task automatic test_byte_write();
        bit got; exp_t e; int t0;
        poke(16'h0300, 8'h00); poke(16'h0301, 8'hC3);
        drive_p(0, 1, 0, 16'h0300, 16'h5A77);
        t0 = cyc;
        push_exp(0, 2, 0, 16'h0000);
        wait_ack(8, got);
        checks++;
        if (!got) begin failures++; $display("FAIL bw_ack: got timeout want ack"); end
        else begin
            e = sbq.pop_front();
            checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL bw_port: got %b want port %0d", {p1_ack, p0_ack}, e.port); end
            checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL bw_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (p0_rdata !== 16'h0080) begin failures++; $display("FAIL bw_rdata_hold: got %h want 0080", p0_rdata); end
        end
        @(posedge clk); #1;
        release_p(0);
        checks++; if (mem[16'h0300] !== 8'h77 || mem[16'h0301] !== 8'hC3) begin failures++; $display("FAIL bw_mem: got %h %h want 77 c3", mem[16'h0300], mem[16'h0301]); end
    endtask

    task automatic test_busy();
        bit got; exp_t e; int t0;
        poke(16'h3333, 8'h99);
        drive_p(0, 0, 1, 16'h1000, 16'h0000);
        t0 = cyc;
        push_exp(0, 4, 1, 16'hBEEF);
        push_exp(1, 8, 1, 16'h0080);
        @(posedge clk); #1;
        drive_p(1, 0, 0, 16'h0200, 16'h0000);
        @(posedge clk); #1;
        p0_addr = 16'h3333; p0_we = 1; p0_wdata = 16'h5555;
        release_p(0);
        for (int n = 0; n < 2; n++) begin
            wait_ack(10, got);
            checks++;
            if (!got) begin failures++; $display("FAIL busy_ack%0d: got timeout want ack", n); end
            else begin
                e = sbq.pop_front();
                checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL busy_port%0d: got %b want port %0d", n, {p1_ack, p0_ack}, e.port); end
                checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL busy_latency%0d: got %0d want %0d", n, cyc - t0, e.lat); end
                checks++; if ((e.port ? p1_rdata : p0_rdata) !== e.rdata) begin failures++; $display("FAIL busy_rdata%0d: got %h want %h", n, e.port ? p1_rdata : p0_rdata, e.rdata); end
            end
        end
        @(posedge clk); #1;
        release_p(1);
        checks++; if (mem[16'h3333] !== 8'h99) begin failures++; $display("FAIL busy_no_write: got %h want 99", mem[16'h3333]); end
    endtask

    task automatic test_fair();
        bit got; exp_t e; int t0;
        poke(16'h0500, 8'h00); poke(16'h0501, 8'h00);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        drive_p(0, 1, 0, 16'h0500, 16'h0011);
        drive_p(1, 1, 0, 16'h0501, 16'h0022);
        t0 = cyc;
        for (int n = 0; n < 4; n++) push_exp(n[0], 3 * n + 2, 0, 16'h0000);
        for (int n = 0; n < 4; n++) begin
            wait_ack(10, got);
            checks++;
            if (!got) begin failures++; $display("FAIL fair_ack%0d: got timeout want ack", n); end
            else begin
                e = sbq.pop_front();
                checks++; if ({p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fair_port%0d: got %b want port %0d", n, {p1_ack, p0_ack}, e.port); end
                checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL fair_latency%0d: got %0d want %0d", n, cyc - t0, e.lat); end
                checks++; if ({f_p1_ack, f_p0_ack} !== 2'b01) begin failures++; $display("FAIL fixed_port%0d: got %b want 01", n, {f_p1_ack, f_p0_ack}); end
            end
        end
        @(posedge clk); #1;
        release_p(0); release_p(1);
        checks++; if (mem[16'h0500] !== 8'h11 || mem[16'h0501] !== 8'h22) begin failures++; $display("FAIL fair_mem: got %h %h want 11 22", mem[16'h0500], mem[16'h0501]); end
    endtask

    task automatic test_reset_abort();
        bit got; bit bad; exp_t e; int t0;
        poke(16'h0040, 8'h5C); poke(16'h0041, 8'h5C);
        drive_p(0, 1, 1, 16'h0040, 16'hAB12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        release_p(0);
        checks++; if (m_we !== 1'b0 || m_waddr !== 16'h0000) begin failures++; $display("FAIL abort_idle_out: got %b %h want 0 0000", m_we, m_waddr); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack || m_we) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL abort_quiet: got activity=%b want 0", bad); end
        checks++; if (mem[16'h0040] !== 8'h12 || mem[16'h0041] !== 8'h5C) begin failures++; $display("FAIL abort_mem: got %h %h want 12 5c", mem[16'h0040], mem[16'h0041]); end
        @(posedge clk); #1;
        drive_p(1, 0, 0, 16'h0040, 16'h0000);
        t0 = cyc;
        push_exp(1, 3, 1, 16'h0012);
        wait_ack(8, got);
        checks++;
        if (!got) begin failures++; $display("FAIL abort_next_ack: got timeout want ack"); end
        else begin
            e = sbq.pop_front();
            checks++; if (cyc - t0 !== e.lat) begin failures++; $display("FAIL abort_next_latency: got %0d want %0d", cyc - t0, e.lat); end
            checks++; if (p1_rdata !== e.rdata) begin failures++; $display("FAIL abort_next_rdata: got %h want %h", p1_rdata, e.rdata); end
        end
        @(posedge clk); #1;
        release_p(1);
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_word_write();
        test_word_read_wrap();
        test_byte_read();
        test_byte_write();
        test_busy();
        test_fair();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aap_dmem_arbiter.md
AAP_DMEM_ARBITER -- requirements
Module: aap_dmem_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 first.
REQ-002 SHALL have port clk, input, 1: clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports p0_req and p1_req, input, 1 each: access request; port 0 is the CPU, port 1 is debug.
REQ-005 SHALL have ports p0_we and p1_we, input, 1 each: 1 selects write, 0 selects read.
REQ-006 SHALL have ports p0_word and p1_word, input, 1 each: 1 selects a 16-bit access, 0 selects an 8-bit access.
REQ-007 SHALL have ports p0_addr and p1_addr, input, 16 each: byte address; any alignment is allowed.
REQ-008 SHALL have ports p0_wdata and p1_wdata, input, 16 each: write data; byte accesses use bits [7:0].
REQ-009 SHALL have ports p0_ack and p1_ack, output, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports p0_rdata and p1_rdata, output, 16 each: read result, valid while ack is high and held until that port's next read ack.
REQ-011 SHALL have ports m_raddr and m_waddr, output, 16 each: byte-memory addresses; both carry the same value.
REQ-012 SHALL have port m_rdata, input, 8: byte-memory read data, valid in the cycle after m_raddr is presented.
REQ-013 SHALL have ports m_wdata (output, 8) and m_we (output, 1): write byte and write enable; memory writes on the clock edge where m_we=1.

Function
REQ-014 SHALL implement states IDLE, LO, HI, CAP, ACK.
REQ-015 IDLE SHALL sample requests, grant at most one, latch that requester's we/word/addr/wdata and grant id, then go to LO; with no request it SHALL stay in IDLE.
REQ-016 Arbitration when both ports request: FAIR=0 grants port 0; FAIR=1 grants the port not granted last.
REQ-017 The last-granted indicator SHALL update only on a grant.
REQ-018 LO SHALL drive the address as the latched addr; on a write it SHALL also drive m_we=1 and m_wdata=wdata[7:0].
REQ-019 From LO the next state SHALL be HI for a word access, CAP for a byte read, and ACK for a byte write.
REQ-020 HI SHALL drive the address as addr+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 In HI a write SHALL drive m_we=1 and m_wdata=wdata[15:8]; a read SHALL capture m_rdata as the low result byte.
REQ-022 From HI the next state SHALL be CAP for a read and ACK for a write.
REQ-023 CAP SHALL capture m_rdata as the high byte of a word read, or as the low byte of a byte read with bits [15:8]=0, then go to ACK.
REQ-024 ACK SHALL pulse the granted port's ack for exactly one cycle, update that port's rdata if the access was a read, then go to IDLE.
REQ-025 Byte order SHALL be little-endian: low byte at addr, high byte at addr+1.
REQ-026 Counting the IDLE sampling cycle as cycle 0, ack SHALL be high in cycle 2 for a byte write, cycle 3 for a byte read or word write, and cycle 4 for a word read.
REQ-027 Outside LO/HI writes, m_we SHALL be 0.
REQ-028 In IDLE, CAP and ACK the address outputs SHALL show the last driven byte address, and m_wdata SHALL hold its last value.
REQ-029 A requester SHALL hold req and its fields stable until ack, and drop req or present a new request in the cycle after ack.
REQ-030 Requests SHALL be ignored outside IDLE; field or req changes after the grant SHALL not affect the transfer in progress.
REQ-031 There SHALL be at least one IDLE cycle between transfers, so the maximum rate is one transfer per 3-5 cycles.
REQ-032 Only one ack SHALL ever be high in any cycle.

Reset
REQ-033 On rst=1 at a clock edge: state SHALL become IDLE, ack outputs 0, m_we 0, address outputs 0x0000, m_wdata 0x00, both rdata 0x0000, and last-granted = port 1 (so port 0 wins the first contention).
REQ-034 Reset during a transfer SHALL abort it with no ack; any byte already written SHALL stay written.
REQ-035 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-036 Port 0 word write, addr 0x1000, wdata 0xBEEF -> 0xEF written to 0x1000 in cycle 1, 0xBE to 0x1001 in cycle 2, p0_ack high in cycle 3 only.
REQ-037 Port 1 word read at 0xFFFF with mem[0xFFFF]=0x34 and mem[0x0000]=0x12 -> address sequence 0xFFFF then 0x0000; p1_ack high in cycle 4 with p1_rdata=0x1234.
REQ-038 Port 0 byte read at 0x0200 with mem=0x80 -> p0_ack high in cycle 3 with p0_rdata=0x0080; p1_rdata stays unchanged.
REQ-039 FAIR=1, both ports hold req with back-to-back byte writes -> grants alternate 0,1,0,1 starting with port 0; with FAIR=0 only port 0 is granted.
REQ-040 rst asserted in HI of a word write 0xAB12 to 0x0040 -> mem[0x0040]=0x12, mem[0x0041] unchanged, no ack, m_we=0 from the next cycle, state IDLE.
REQ-041 A request arriving while a transfer is busy, and req dropped mid-transfer -> the busy transfer completes unaffected and the waiting port is granted at the next IDLE.
